lcd_frame_buffer: RTL and testbench

- 32-character frame buffer (2 lines x 16) that sits directly upstream of the LCD controller.
- Application logic writes ASCII characters by address or through an auto-incrementing cursor, and can bulk-clear the buffer.
- The LCD controller reads characters by index during each refresh pass.
- A dirty/ack handshake tells the controller when the content has changed since its last pass.

---
 rtl/lcd_frame_buffer.sv | 164 ++++++++++++++++
 tb/tb_lcd_frame_buffer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : lcd_frame_buffer
// Purpose  : 32-character (2 x 16) frame buffer placed upstream of the LCD
//            controller. The application writes characters either at an
//            explicit index or at an auto-incrementing cursor, and can
//            bulk-clear the whole buffer. The controller reads characters by
//            index. A dirty/ack handshake signals changed content.
// Ports    : clk          system clock
//            rst          asynchronous active-low reset
//            wr_en        write strobe, one character per cycle
//            wr_auto      1 = write at cursor, 0 = write at wr_addr
//            wr_addr      write index (0-15 line 1, 16-31 line 2)
//            wr_data      character code
//            clr          single-cycle pulse starting a bulk clear
//            busy         high while a clear is in progress
//            cursor       next auto-write index
//            rd_addr      read index from the LCD controller
//            rd_data      registered character at rd_addr (1-cycle latency)
//            frame_dirty  content changed since the last frame_ack
//            frame_ack    controller starting a refresh pass (pulse)
// Revision : 1.0 - initial release
// ============================================================================
module lcd_frame_buffer #(
    parameter logic [7:0] BLANK_CHAR = 8'h20,
    parameter int         WRAP       = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic       wr_auto,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       clr,
    output logic       busy,
    output logic [4:0] cursor,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data,
    output logic       frame_dirty,
    input  logic       frame_ack
);

    localparam logic [4:0] c_LAST_IDX = 5'd31;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_mem [0:31];
    logic [7:0] r_rd_data;
    logic [4:0] r_cursor;
    logic [4:0] r_clr_cnt;
    logic       r_dirty;

    logic       w_we;
    logic [4:0] w_waddr;
    logic [7:0] w_wdata;
    logic [4:0] w_cursor_nxt;
    logic [4:0] w_cnt_nxt;
    logic       w_set_dirty;

    // Cursor step past the last index either wraps or saturates.
    function automatic logic [4:0] f_advance(input logic [4:0] idx);
        if (idx == c_LAST_IDX) begin
            return (WRAP != 0) ? 5'd0 : c_LAST_IDX;
        end
        return idx + 5'd1;
    endfunction

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and write-port decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_we         = 1'b0;
        w_waddr      = r_cursor;
        w_wdata      = wr_data;
        w_cursor_nxt = r_cursor;
        w_cnt_nxt    = r_clr_cnt;
        w_set_dirty  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // clr wins over a same-cycle write; the write is dropped.
                if (clr) begin
                    w_state_nxt = S_CLEAR;
                end else if (wr_en) begin
                    w_we         = 1'b1;
                    w_waddr      = wr_auto ? r_cursor : wr_addr;
                    w_cursor_nxt = f_advance(w_waddr);
                    w_set_dirty  = 1'b1;
                end
            end
            S_CLEAR: begin
                // One entry blanked per cycle; wr_en/clr are ignored here.
                w_we        = 1'b1;
                w_waddr     = r_clr_cnt;
                w_wdata     = BLANK_CHAR;
                w_set_dirty = 1'b1;
                if (r_clr_cnt == c_LAST_IDX) begin
                    w_cnt_nxt    = 5'd0;
                    w_cursor_nxt = 5'd0;
                    w_state_nxt  = S_IDLE;
                end else begin
                    w_cnt_nxt = r_clr_cnt + 5'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Storage, read port, cursor, clear counter and dirty flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                r_mem[i] <= BLANK_CHAR;
            end
            r_rd_data <= BLANK_CHAR;
            r_cursor  <= 5'd0;
            r_clr_cnt <= 5'd0;
            // Dirty out of reset so the first pass draws the blank screen.
            r_dirty   <= 1'b1;
        end else begin
            // Read samples the pre-write contents (read-before-write).
            r_rd_data <= r_mem[rd_addr];
            if (w_we) begin
                r_mem[w_waddr] <= w_wdata;
            end
            r_cursor  <= w_cursor_nxt;
            r_clr_cnt <= w_cnt_nxt;
            // A set event outranks a same-cycle ack so no update is lost.
            if (w_set_dirty) begin
                r_dirty <= 1'b1;
            end else if (frame_ack) begin
                r_dirty <= 1'b0;
            end
        end
    end

    assign busy        = (r_state == S_CLEAR);
    assign cursor      = r_cursor;
    assign rd_data     = r_rd_data;
    assign frame_dirty = r_dirty;

endmodule
`default_nettype wire

// File: tb/tb_lcd_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lcd_frame_buffer
// Purpose  : Self-checking bench for lcd_frame_buffer. Two instances share
//            the stimulus: one wrapping cursor, one saturating cursor. A
//            behavioural buffer model is compared against both every cycle,
//            and directed checks pin hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lcd_frame_buffer;

    localparam logic [7:0] c_BLANK = 8'h20;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic       wr_auto;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       clr;
    logic [4:0] rd_addr;
    logic       frame_ack;

    logic       busy_a,  busy_b;
    logic [4:0] cursor_a, cursor_b;
    logic [7:0] rd_a,    rd_b;
    logic       dirty_a, dirty_b;

    int total = 0;
    int bad   = 0;
    logic chk_on = 1'b0;

    lcd_frame_buffer #(.BLANK_CHAR(8'h20), .WRAP(1)) u_dut_wrap (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_auto(wr_auto),
        .wr_addr(wr_addr), .wr_data(wr_data), .clr(clr), .busy(busy_a),
        .cursor(cursor_a), .rd_addr(rd_addr), .rd_data(rd_a),
        .frame_dirty(dirty_a), .frame_ack(frame_ack)
    );

    lcd_frame_buffer #(.BLANK_CHAR(8'h20), .WRAP(0)) u_dut_sat (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_auto(wr_auto),
        .wr_addr(wr_addr), .wr_data(wr_data), .clr(clr), .busy(busy_b),
        .cursor(cursor_b), .rd_addr(rd_addr), .rd_data(rd_b),
        .frame_dirty(dirty_b), .frame_ack(frame_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: index 0 = wrapping instance, 1 = saturating.
    // ------------------------------------------------------------------
    logic [7:0] m_mem [2][32];
    int         m_cur [2];
    int         m_left[2];   // clear entries still to blank; 0 = not busy
    logic       m_dirty[2];
    logic [7:0] m_rd  [2];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int n = 0; n < 2; n++) begin
                for (int j = 0; j < 32; j++) m_mem[n][j] = c_BLANK;
                m_cur[n]   = 0;
                m_left[n]  = 0;
                m_dirty[n] = 1'b1;
                m_rd[n]    = c_BLANK;
            end
        end else begin
            for (int n = 0; n < 2; n++) begin
                int  idx;
                bit  touched;
                touched  = 0;
                m_rd[n]  = m_mem[n][rd_addr];
                if (m_left[n] > 0) begin
                    m_mem[n][32 - m_left[n]] = c_BLANK;
                    m_left[n] = m_left[n] - 1;
                    touched   = 1;
                    if (m_left[n] == 0) m_cur[n] = 0;
                end else if (clr) begin
                    m_left[n] = 32;
                end else if (wr_en) begin
                    idx = wr_auto ? m_cur[n] : int'(wr_addr);
                    m_mem[n][idx] = wr_data;
                    if (idx < 31)    m_cur[n] = idx + 1;
                    else if (n == 0) m_cur[n] = 0;
                    else             m_cur[n] = 31;
                    touched = 1;
                end
                if (touched)        m_dirty[n] = 1'b1;
                else if (frame_ack) m_dirty[n] = 1'b0;
            end
        end
    end

    // Per-cycle comparison away from the active edge.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_rd_wrap",    {24'd0, rd_a},      {24'd0, m_rd[0]});
            chk("model_rd_sat",     {24'd0, rd_b},      {24'd0, m_rd[1]});
            chk("model_cur_wrap",   {27'd0, cursor_a},  m_cur[0]);
            chk("model_cur_sat",    {27'd0, cursor_b},  m_cur[1]);
            chk("model_busy_wrap",  {31'd0, busy_a},    {31'd0, m_left[0] > 0});
            chk("model_busy_sat",   {31'd0, busy_b},    {31'd0, m_left[1] > 0});
            chk("model_dirty_wrap", {31'd0, dirty_a},   {31'd0, m_dirty[0]});
            chk("model_dirty_sat",  {31'd0, dirty_b},   {31'd0, m_dirty[1]});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; wr_auto = 1'b0; clr = 1'b0; frame_ack = 1'b0;
    endtask

    task automatic wr(input logic auto_mode, input logic [4:0] a, input logic [7:0] d);
        wr_en = 1'b1; wr_auto = auto_mode; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0; wr_auto = 1'b0;
    endtask

    task automatic rd_check(input string nm, input logic [4:0] a,
                            input logic [7:0] exp_a, input logic [7:0] exp_b);
        rd_addr = a;
        tick();
        chk({nm, "_wrap"}, {24'd0, rd_a}, {24'd0, exp_a});
        chk({nm, "_sat"},  {24'd0, rd_b}, {24'd0, exp_b});
    endtask

    initial begin
        int nbusy;
        rst = 1'b1; wr_addr = 5'd0; wr_data = 8'd0; rd_addr = 5'd0;
        idle_inputs();

        // Reset
        #1 rst = 1'b0;
        chk_on = 1'b1;
        repeat (3) tick();
        rst = 1'b1;
        chk("reset_busy",   {31'd0, busy_a},   32'd0);
        chk("reset_cursor", {27'd0, cursor_a}, 32'd0);
        chk("reset_dirty",  {31'd0, dirty_a},  32'd1);
        for (int i = 0; i < 32; i++) rd_check("reset_rd", 5'(i), 8'h20, 8'h20);
        chk("dirty_before_ack", {31'd0, dirty_a}, 32'd1);
        frame_ack = 1'b1; tick(); frame_ack = 1'b0;
        chk("dirty_after_ack", {31'd0, dirty_a}, 32'd0);

        // Auto write with wrap / saturate
        wr(1'b0, 5'd30, 8'h41);
        wr(1'b1, 5'd0,  8'h42);
        wr(1'b1, 5'd0,  8'h43);
        chk("wrap_cursor", {27'd0, cursor_a}, 32'd1);
        chk("sat_cursor",  {27'd0, cursor_b}, 32'd31);
        chk("wrap_dirty",  {31'd0, dirty_a},  32'd1);
        rd_check("wrap_m30", 5'd30, 8'h41, 8'h41);
        rd_check("wrap_m31", 5'd31, 8'h42, 8'h43);
        rd_check("wrap_m0",  5'd0,  8'h43, 8'h20);

        // Saturating cursor
        wr(1'b0, 5'd31, 8'h57);
        chk("sat_cur_1", {27'd0, cursor_b}, 32'd31);
        wr(1'b1, 5'd0, 8'h58);
        chk("sat_cur_2", {27'd0, cursor_b}, 32'd31);
        wr(1'b1, 5'd0, 8'h59);
        chk("sat_cur_3", {27'd0, cursor_b}, 32'd31);
        rd_check("sat_m31", 5'd31, 8'h57, 8'h59);
        rd_check("sat_m1",  5'd1,  8'h59, 8'h20);

        // Clear with a colliding write and writes held during busy
        for (int i = 0; i < 32; i++) wr(1'b0, 5'(i), 8'h30);
        clr = 1'b1; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 8'h5A;
        tick();
        clr = 1'b0; wr_addr = 5'd9; wr_data = 8'h77;
        nbusy = 0;
        while (busy_a && nbusy < 40) begin
            wr_auto = ~wr_auto;
            clr     = nbusy[0];
            tick();
            nbusy++;
        end
        idle_inputs();
        chk("clear_busy_cycles", nbusy, 32'd32);
        chk("clear_cursor", {27'd0, cursor_a}, 32'd0);
        for (int i = 0; i < 32; i++) rd_check("clear_rd", 5'(i), 8'h20, 8'h20);

        // Dirty race
        frame_ack = 1'b1; tick(); frame_ack = 1'b0;
        chk("race_pre", {31'd0, dirty_a}, 32'd0);
        frame_ack = 1'b1; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 8'h31;
        tick();
        idle_inputs();
        chk("race_dirty_kept", {31'd0, dirty_a}, 32'd1);
        frame_ack = 1'b1; tick(); frame_ack = 1'b0;
        chk("race_dirty_cleared", {31'd0, dirty_a}, 32'd0);

        // Read during write to the same index
        rd_addr = 5'd7;
        wr(1'b0, 5'd7, 8'h32);
        chk("rdw_old", {24'd0, rd_a}, 32'h31);
        tick();
        chk("rdw_new", {24'd0, rd_a}, 32'h32);

        // Reset in the middle of a clear (counter at 10)
        clr = 1'b1; tick(); clr = 1'b0;
        repeat (10) tick();
        chk("midclr_busy_pre", {31'd0, busy_a}, 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("midclr_busy_async", {31'd0, busy_a},   32'd0);
        chk("midclr_busy_sat",   {31'd0, busy_b},   32'd0);
        chk("midclr_cursor",     {27'd0, cursor_a}, 32'd0);
        chk("midclr_dirty",      {31'd0, dirty_a},  32'd1);
        chk("midclr_rd",         {24'd0, rd_a},     32'h20);
        tick();
        rst = 1'b1;
        rd_check("post_rst_m7",  5'd7,  8'h20, 8'h20);
        rd_check("post_rst_m30", 5'd30, 8'h20, 8'h20);
        tick();

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
